// File: rtl/disk_image_rx_if.sv
// Bus between the image source (master) and the disk image receiver (slave):
// the asynchronous strobe stream, the track-RAM write port and the receiver status.
interface disk_image_rx_if #(
    parameter int ADDR_W  = 19,
    parameter int DRIVE_W = 1
);
    logic               image_clk;
    logic               image_start;
    logic [7:0]         image_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [7:0]         wr_data;
    logic [5:0]         track;
    logic [DRIVE_W-1:0] drive;
    logic               busy;
    logic               done;
    logic               error;

    modport master (
        output image_clk, image_start, image_data,
        input  wr_en, wr_addr, wr_data, track, drive, busy, done, error
    );

    modport slave (
        input  image_clk, image_start, image_data,
        output wr_en, wr_addr, wr_data, track, drive, busy, done, error
    );
endinterface

// File: rtl/disk_image_rx.sv
// Disk image receiver: writes a strobed byte stream into track RAM at linear addresses.
// Optional DISK_IMAGE_RX_CHECKSUM_EN: the stop byte must match the XOR of all data bytes.
//
// state | meaning
// IDLE  | waiting for a start strobe (also holds error/done after abort or checked stop)
// RECV  | writing image bytes, one per strobe
// TRAIL | all bytes written, waiting for the stop strobe
// DONE  | image complete, behaves as IDLE
module disk_image_rx #(
    parameter int NUM_TRACKS     = 35,
    parameter int TRACK_BYTES    = 6656,
    parameter int NUM_DRIVES     = 2,
    parameter int DRIVE_W        = 1,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic             CLK_14M,
    input logic             RESET,
    disk_image_rx_if.slave  bus
);
    localparam int IMG_BYTES = NUM_TRACKS * TRACK_BYTES;
    localparam int OFF_W     = (TRACK_BYTES > 1) ? $clog2(TRACK_BYTES) : 1;
    localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, RECV, TRAIL, DONE} state_t;

    state_t             state, state_nxt;
    logic               s1, s2, s3, ev, ev_q, start_q;
    logic [7:0]         data_q;
    logic [ADDR_W-1:0]  addr, addr_nxt, wr_addr, wr_addr_nxt, base_sel;
    logic [OFF_W-1:0]   offset, offset_nxt;
    logic [5:0]         track, track_nxt;
    logic [DRIVE_W-1:0] drive, drive_nxt, drive_sel;
    logic [TO_W-1:0]    tmo, tmo_nxt;
    logic [7:0]         wr_data, wr_data_nxt;
    logic               wr_en, wr_en_nxt, done, done_nxt, error, error_nxt;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
    logic [7:0]         csum, csum_nxt;
`endif

    assign ev = s2 & ~s3;

    // Drive index wraps modulo NUM_DRIVES; the slot base is a mux of constants.
    always_comb begin
        drive_sel = '0;
        base_sel  = '0;
        for (int d = 0; d < 2**DRIVE_W; d++) begin
            if (data_q[DRIVE_W-1:0] == DRIVE_W'(d)) begin
                drive_sel = DRIVE_W'(d % NUM_DRIVES);
                base_sel  = ADDR_W'((d % NUM_DRIVES) * IMG_BYTES);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        offset_nxt  = offset;
        track_nxt   = track;
        drive_nxt   = drive;
        done_nxt    = done;
        error_nxt   = error;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        tmo_nxt     = '0;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
        csum_nxt    = csum;
`endif
        if (ev_q && start_q) begin
            state_nxt  = RECV;
            drive_nxt  = drive_sel;
            addr_nxt   = base_sel;
            offset_nxt = '0;
            track_nxt  = '0;
            done_nxt   = 1'b0;
            error_nxt  = 1'b0;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
            csum_nxt   = '0;
`endif
        end else if (state == RECV || state == TRAIL) begin
            if (ev_q && state == RECV) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = addr;
                wr_data_nxt = data_q;
                addr_nxt    = addr + ADDR_W'(1);
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
                csum_nxt    = csum ^ data_q;
`endif
                if (offset == OFF_W'(TRACK_BYTES - 1)) begin
                    offset_nxt = '0;
                    if (track == 6'(NUM_TRACKS - 1))
                        state_nxt = TRAIL;
                    else
                        track_nxt = track + 6'd1;
                end else begin
                    offset_nxt = offset + OFF_W'(1);
                end
            end else if (ev_q) begin
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
                state_nxt = IDLE;
                if (data_q == csum)
                    done_nxt  = 1'b1;
                else
                    error_nxt = 1'b1;
`else
                state_nxt = DONE;
                done_nxt  = 1'b1;
`endif
            end else if (TIMEOUT_CYCLES != 0) begin
                // Idle time is counted from the cycle the last event's write is issued.
                if (tmo == TO_W'(TO_LAST)) begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo + TO_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_14M) begin
        if (RESET) begin
            state   <= IDLE;
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            ev_q    <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            addr    <= '0;
            offset  <= '0;
            track   <= '0;
            drive   <= '0;
            tmo     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            error   <= 1'b0;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
            csum    <= '0;
`endif
        end else begin
            s1      <= bus.image_clk;
            s2      <= s1;
            s3      <= s2;
            ev_q    <= ev;
            if (ev) begin
                start_q <= bus.image_start;
                data_q  <= bus.image_data;
            end
            state   <= state_nxt;
            addr    <= addr_nxt;
            offset  <= offset_nxt;
            track   <= track_nxt;
            drive   <= drive_nxt;
            tmo     <= tmo_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
            done    <= done_nxt;
            error   <= error_nxt;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
            csum    <= csum_nxt;
`endif
        end
    end

    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
    assign bus.track   = track;
    assign bus.drive   = drive;
    assign bus.busy    = (state == RECV) || (state == TRAIL);
    assign bus.done    = done;
    assign bus.error   = error;
endmodule

// File: tb/tb_disk_image_rx.sv
// Directed bench for disk_image_rx in a reduced 2x4, two-drive geometry with a 100-cycle timeout.
// Works with or without DISK_IMAGE_RX_CHECKSUM_EN defined.
module tb_disk_image_rx;
    localparam int ADDR_W  = 5;
    localparam int DRIVE_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [7:0]        log_data[$];
    int                log_cyc[$];

    disk_image_rx_if #(.ADDR_W(ADDR_W), .DRIVE_W(DRIVE_W)) bus ();

    disk_image_rx #(
        .NUM_TRACKS(2), .TRACK_BYTES(4), .NUM_DRIVES(2), .DRIVE_W(DRIVE_W),
        .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(100)
    ) dut (
        .CLK_14M(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #35 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            log_addr.push_back(bus.wr_addr);
            log_data.push_back(bus.wr_data);
            log_cyc.push_back(cyc);
        end
    end

    // One strobe: 4 cycles high, 3 low; called and returns on a falling clock edge.
    task automatic strobe(input logic st, input logic [7:0] d);
        bus.image_start = st;
        bus.image_data  = d;
        bus.image_clk   = 1'b1;
        repeat (4) @(negedge clk);
        bus.image_clk   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int mark;
        bus.image_clk   = 1'b0;
        bus.image_start = 1'b0;
        bus.image_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.track, bus.drive, bus.busy, bus.done, bus.error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h track=%0d drive=%0d busy=%b done=%b error=%b, want all 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.track, bus.drive, bus.busy, bus.done, bus.error);
        end
        mark = log_addr.size();
        strobe(1'b0, 8'h5A);
        vectors++;
        if (log_addr.size() != mark || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_data_ignored: writes=%0d busy=%b, want writes=0 busy=0", log_addr.size() - mark, bus.busy);
        end
    endtask

    task automatic test_image(input logic [7:0] start_byte, input int base, input int exp_drive);
        int mark;
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        mark = log_addr.size();
        strobe(1'b1, start_byte);
        vectors++;
        if (bus.busy !== 1'b1 || bus.drive !== DRIVE_W'(exp_drive) || bus.track !== 6'd0 || log_addr.size() != mark) begin
            miscompares++;
            $display("FAIL img_start: busy=%b drive=%0d track=%0d writes=%0d, want busy=1 drive=%0d track=0 writes=0",
                     bus.busy, bus.drive, bus.track, log_addr.size() - mark, exp_drive);
        end
        for (int k = 0; k < 8; k++) begin
            b = 8'((k / 4) + (k % 4));
            x = x ^ b;
            strobe(1'b0, b);
            vectors++;
            if (bus.track !== ((k >= 3) ? 6'd1 : 6'd0)) begin
                miscompares++;
                $display("FAIL img_track[%0d]: got %0d, want %0d", k, bus.track, (k >= 3) ? 1 : 0);
            end
        end
        vectors++;
        if (log_addr.size() != mark + 8) begin
            miscompares++;
            $display("FAIL img_write_count: got %0d, want 8", log_addr.size() - mark);
        end else begin
            for (int k = 0; k < 8; k++) begin
                vectors++;
                if (log_addr[mark+k] !== ADDR_W'(base + k) || log_data[mark+k] !== 8'((k / 4) + (k % 4))) begin
                    miscompares++;
                    $display("FAIL img_write[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                             k, log_addr[mark+k], log_data[mark+k], base + k, (k / 4) + (k % 4));
                end
            end
        end
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.track !== 6'd1) begin
            miscompares++;
            $display("FAIL img_trail: busy=%b done=%b track=%0d, want busy=1 done=0 track=1", bus.busy, bus.done, bus.track);
        end
        strobe(1'b0, x);
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0 || log_addr.size() != mark + 8) begin
            miscompares++;
            $display("FAIL img_stop: done=%b busy=%b error=%b writes=%0d, want done=1 busy=0 error=0 writes=8",
                     bus.done, bus.busy, bus.error, log_addr.size() - mark);
        end
    endtask

    task automatic test_latency();
        strobe(1'b1, 8'h00);
        bus.image_start = 1'b0;
        bus.image_data  = 8'hA5;
        bus.image_clk   = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: wr_en=%b two cycles after capture, want 0", bus.wr_en);
        end
        @(negedge clk);
        vectors++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== ADDR_W'(0) || bus.wr_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL latency_write: wr_en=%b addr=%0d data=%h, want 1 0 a5", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        bus.image_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_restart();
        int mark;
        strobe(1'b1, 8'h02);
        for (int k = 0; k < 5; k++) strobe(1'b0, 8'(8'h30 + k));
        mark = log_addr.size();
        strobe(1'b1, 8'h00);
        vectors++;
        if (log_addr.size() != mark || bus.track !== 6'd0 || bus.busy !== 1'b1 || bus.error !== 1'b0 || bus.drive !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_cycle: writes=%0d track=%0d busy=%b error=%b drive=%0d, want 0 0 1 0 0",
                     log_addr.size() - mark, bus.track, bus.busy, bus.error, bus.drive);
        end
        strobe(1'b0, 8'h77);
        vectors++;
        if (log_addr.size() != mark + 1 || log_addr[$] !== ADDR_W'(0) || log_data[$] !== 8'h77) begin
            miscompares++;
            $display("FAIL restart_first_write: writes=%0d addr=%0d data=%h, want 1 0 77",
                     log_addr.size() - mark, log_addr[$], log_data[$]);
        end
    endtask

    task automatic test_timeout();
        int mark;
        int last_wr;
        strobe(1'b1, 8'h01);
        for (int k = 0; k < 3; k++) strobe(1'b0, 8'(8'h40 + k));
        last_wr = log_cyc[$];
        mark = log_addr.size();
        for (int k = 0; k < 300 && bus.error !== 1'b1; k++) @(negedge clk);
        vectors++;
        if (bus.error !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: error=%b after 300 cycles, want 1", bus.error);
        end else if (cyc - last_wr != 100) begin
            miscompares++;
            $display("FAIL timeout_delay: error after %0d cycles, want 100", cyc - last_wr);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || log_addr.size() != mark) begin
            miscompares++;
            $display("FAIL timeout_after: busy=%b done=%b writes=%0d, want 0 0 0", bus.busy, bus.done, log_addr.size() - mark);
        end
        strobe(1'b0, 8'h99);
        vectors++;
        if (log_addr.size() != mark || bus.error !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_idle: writes=%0d error=%b, want 0 1", log_addr.size() - mark, bus.error);
        end
    endtask

    task automatic send_cs_image(input logic [7:0] stop_byte);
        logic [7:0] bytes [8];
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        strobe(1'b1, 8'h00);
        for (int k = 0; k < 8; k++) strobe(1'b0, bytes[k]);
        strobe(1'b0, stop_byte);
    endtask

    task automatic test_checksum();
        // XOR of the eight bytes is 0x01.
        send_cs_image(8'h01);
        vectors++;
        if (bus.done !== 1'b1 || bus.error !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_match: done=%b error=%b, want 1 0", bus.done, bus.error);
        end
        send_cs_image(8'h00);
        vectors++;
`ifdef DISK_IMAGE_RX_CHECKSUM_EN
        if (bus.done !== 1'b0 || bus.error !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_mismatch: done=%b error=%b busy=%b, want 0 1 0", bus.done, bus.error, bus.busy);
        end
`else
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cs_ignored: done=%b error=%b busy=%b, want 1 0 0", bus.done, bus.error, bus.busy);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int mark;
        strobe(1'b1, 8'h01);
        strobe(1'b0, 8'h11);
        strobe(1'b0, 8'h22);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.track !== 6'd0 || bus.drive !== 1'b0 || bus.wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: busy=%b track=%0d drive=%0d wr_en=%b, want 0 0 0 0", bus.busy, bus.track, bus.drive, bus.wr_en);
        end
        mark = log_addr.size();
        strobe(1'b0, 8'h33);
        vectors++;
        if (log_addr.size() != mark) begin
            miscompares++;
            $display("FAIL reset_mid_nowrite: writes=%0d, want 0", log_addr.size() - mark);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_image(8'h00, 0, 0);
        test_image(8'h01, 8, 1);
        test_image(8'h03, 8, 1);
        test_latency();
        test_restart();
        test_timeout();
        test_checksum();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/disk_image_rx.md
Name: disk_image_rx

Overview:
- Parametrised receiver for disk images streamed over a slow strobe interface: `image_clk`, `image_start`, `image_data`.
- The strobe is asynchronous to the core clock. Each byte is written into the track-buffer RAM at a linear address.
- Generalises the single-drive, fixed 35x6656 loader: configurable geometry, multiple drive slots, inactivity timeout, status outputs.
- Sits between the external image source and the disk-controller track RAM.

Parameters:
- NUM_TRACKS, 35, tracks per image.
- TRACK_BYTES, 6656, nibble bytes per track.
- NUM_DRIVES, 2, drive slots in RAM; drive index selected at start cycle.
- DRIVE_W, 1, width of the drive index, clog2(NUM_DRIVES) min 1.
- ADDR_W, 19, RAM address width; must hold NUM_DRIVES*NUM_TRACKS*TRACK_BYTES.
- TIMEOUT_CYCLES, 1000000, CLK cycles without a strobe before abort; 0 disables the timeout.

Ports:
- CLK_14M  in  1  core clock.
- RESET  in  1  synchronous, active-high reset.
- image_clk  in  1  async strobe; a rising edge qualifies one cycle.
- image_start  in  1  async; high at a strobe marks the start cycle.
- image_data  in  8  async byte; stable around the strobe.
- wr_en  out  1  one-cycle RAM write strobe.
- wr_addr  out  ADDR_W  RAM address.
- wr_data  out  8  RAM data.
- track  out  6  current track number.
- drive  out  DRIVE_W  drive latched at start.
- busy  out  1  high in RECV/TRAIL.
- done  out  1  image complete; held until the next start or RESET.
- error  out  1  image aborted; held until the next start or RESET.

Behaviour:
- Clock and reset:
  - One clock, CLK_14M. RESET is synchronous, active-high.
  - Reset values: all outputs 0, state IDLE, sync flops 0.
- Synchronisation:
  - `image_clk` passes through 3 flops s1, s2, s3.
  - Strobe event `ev` = s2 & ~s3.
  - `image_start` and `image_data` are sampled on the ev cycle; they are stable for many cycles by protocol.
- Latency: wr_en is asserted exactly 3 CLK cycles after the first edge at which s1 captures 1. wr_addr and wr_data are valid in the same cycle.
- State IDLE:
  - ev with start=1 goes to RECV.
  - Latch drive = image_data[DRIVE_W-1:0]; out-of-range values wrap modulo NUM_DRIVES.
  - offset=0, track=0, done=0, error=0.
  - Linear address base = drive*NUM_TRACKS*TRACK_BYTES, computed by accumulation or constant multiply, not a runtime multiplier.
  - ev with start=0 in IDLE is ignored.
- State RECV, on ev with start=0:
  - wr_en=1, wr_addr=base+track*TRACK_BYTES+offset (running counter), wr_data=byte.
  - If offset==TRACK_BYTES-1: offset wraps to 0 and track increments.
  - When the last byte of track NUM_TRACKS-1 is written, go to TRAIL.
- State TRAIL: the next ev is the stop cycle.
  - Goes to DONE with done=1 unless CHECKSUM_EN fails (see Optional Feature).
  - No write occurs.
- ev with start=1 in RECV, TRAIL or DONE: restart exactly as from IDLE. New drive latched, counters cleared, flags cleared, no write on that cycle.
- State DONE behaves as IDLE for strobes; busy=0.
- Timeout:
  - In RECV or TRAIL, a counter increments each cycle and is cleared on ev.
  - Reaching TIMEOUT_CYCLES goes to IDLE with error=1, busy=0.
- RESET mid-image: immediate return to IDLE, no further writes, partial RAM contents left as written.
- track output reflects the track of the most recent or next write; it reads NUM_TRACKS-1 in TRAIL.

Optional Feature:
- Macro: DISK_IMAGE_RX_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR of all data bytes is accumulated, cleared at the start cycle.
  - The stop-cycle byte must equal the XOR. Equal sets done=1; mismatch sets error=1, done=0. Either way the state returns to IDLE.
- When undefined:
  - The stop-cycle byte is ignored and done=1 always.
  - No accumulator logic is present.

Test Plan:
- Reduced geometry NUM_TRACKS=2, TRACK_BYTES=4, NUM_DRIVES=2, strobe period 500 ns. Start with data 0x00, bytes (t+i)%256, then stop 0x00 (checksum off).
  - Expect 8 writes to addr 0..7 with data 0,1,2,3,1,2,3,4.
  - track steps 0 to 1 after the 4th write.
  - done=1, busy=0, error=0.
- Same stream with start data 0x01 -> writes go to addr 8..15; drive=1.
- Default geometry, strobe period 1 us, full 35x6656 image -> 232960 writes, last addr 232959, track=34, done=1.
- After 5 bytes, assert start again with data 0x00 -> no write on the restart cycle; the next byte goes to addr 0; error stays 0.
- TIMEOUT_CYCLES=100; stop strobes after 3 bytes -> error=1 exactly 100 cycles after the last ev; busy=0; no further writes.
- DISK_IMAGE_RX_CHECKSUM_EN defined, bytes 0x12,0x34,0x56,0x78 (geometry 1x4):
  - Stop byte 0x08 -> done=1.
  - Stop byte 0x09 -> error=1, done=0.
